// File: rtl/vc_dest_arbiter.sv
// Moves words from the two VC FIFOs into the two destination FIFOs. VC0 has strict
// priority, with a burst limit that gives an eligible VC1 one slot.
module vc_dest_arbiter #(
    parameter int DATA_WIDTH    = 6,
    parameter int DEST_BIT      = 4,
    parameter int MAX_VC0_BURST = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  active,
    input  logic                  vc0_empty,
    input  logic                  vc1_empty,
    input  logic [DATA_WIDTH-1:0] vc0_data,
    input  logic [DATA_WIDTH-1:0] vc1_data,
    input  logic                  d0_almost_full,
    input  logic                  d1_almost_full,
    output logic                  pop_vc0,
    output logic                  pop_vc1,
    output logic                  push_d0,
    output logic                  push_d1,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  idle
);

    localparam int CW = $clog2(MAX_VC0_BURST + 1);
    localparam logic [CW-1:0] BURST_MAX = CW'(MAX_VC0_BURST);

    typedef enum logic {DISABLED, RUN} state_t;

    state_t                state, state_next;
    logic [CW-1:0]         burst_cnt, burst_next;
    logic                  dest_af0, dest_af1;
    logic                  elig0, elig1;
    logic [DATA_WIDTH-1:0] sel_word;

    // NOTE: state registers use non-blocking assignments so every flop samples the
    // pre-edge values; blocking here would create order-dependent simulation.
    always_ff @(posedge clk) begin
        if (!reset) state <= DISABLED;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            DISABLED: if (active)  state_next = RUN;
            RUN:      if (!active) state_next = DISABLED;
            default:               state_next = DISABLED;
        endcase
    end

    // NOTE: every comb output gets a default before any branch, so no path leaves a
    // value unassigned and no latch is inferred.
    always_comb begin
        dest_af0   = vc0_data[DEST_BIT] ? d1_almost_full : d0_almost_full;
        dest_af1   = vc1_data[DEST_BIT] ? d1_almost_full : d0_almost_full;
        elig0      = active & ~vc0_empty & ~dest_af0;
        elig1      = active & ~vc1_empty & ~dest_af1;
        pop_vc0    = 1'b0;
        pop_vc1    = 1'b0;
        burst_next = burst_cnt;
        // Pops are gated by reset so a word can never be lost in a reset cycle.
        if (reset && state == RUN) begin
            if (elig0 && !(elig1 && burst_cnt == BURST_MAX)) begin
                pop_vc0    = 1'b1;
                burst_next = (burst_cnt == BURST_MAX) ? BURST_MAX : burst_cnt + 1'b1;
            end else if (elig1) begin
                pop_vc1    = 1'b1;
                burst_next = '0;
            end
        end
        sel_word = pop_vc0 ? vc0_data : vc1_data;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            burst_cnt <= '0;
            push_d0   <= 1'b0;
            push_d1   <= 1'b0;
            data_out  <= '0;
            idle      <= 1'b1;
        end else begin
            burst_cnt <= burst_next;
            push_d0   <= (pop_vc0 | pop_vc1) & ~sel_word[DEST_BIT];
            push_d1   <= (pop_vc0 | pop_vc1) &  sel_word[DEST_BIT];
            idle      <= ~(pop_vc0 | pop_vc1);
            if (pop_vc0 | pop_vc1) data_out <= sel_word;
        end
    end

endmodule

// File: tb/tb_vc_dest_arbiter.sv
// Self-checking bench for vc_dest_arbiter: directed scenarios followed by random traffic,
// compared each cycle against a queue-based reference model.
module tb_vc_dest_arbiter;

    localparam int MAXB = 4;

    logic       clk = 1'b0;
    logic       reset, active;
    logic       vc0_empty, vc1_empty;
    logic [5:0] vc0_data, vc1_data;
    logic       d0_almost_full, d1_almost_full;
    logic       pop_vc0, pop_vc1, push_d0, push_d1, idle;
    logic [5:0] data_out;

    int checks = 0;
    int errors = 0;

    logic [5:0] q0[$];
    logic [5:0] q1[$];

    // Reference model: run flag, consecutive-VC0 grant count and expected registered outputs.
    bit         m_run   = 0;
    int         m_burst = 0;
    logic       m_push0 = 0, m_push1 = 0, m_idle = 1;
    logic [5:0] m_data  = '0;

    vc_dest_arbiter dut (
        .clk(clk), .reset(reset), .active(active),
        .vc0_empty(vc0_empty), .vc1_empty(vc1_empty),
        .vc0_data(vc0_data), .vc1_data(vc1_data),
        .d0_almost_full(d0_almost_full), .d1_almost_full(d1_almost_full),
        .pop_vc0(pop_vc0), .pop_vc1(pop_vc1),
        .push_d0(push_d0), .push_d1(push_d1),
        .data_out(data_out), .idle(idle)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit dest_full(input logic [5:0] w);
        return w[4] ? d1_almost_full : d0_almost_full;
    endfunction

    // One clock cycle: present FIFO heads, check at negedge, update model at posedge.
    task automatic run_cycle(input string tag);
        bit e0, e1, p0, p1;
        logic [5:0] w;
        vc0_empty = (q0.size() == 0);
        vc1_empty = (q1.size() == 0);
        vc0_data  = (q0.size() != 0) ? q0[0] : 6'($urandom);
        vc1_data  = (q1.size() != 0) ? q1[0] : 6'($urandom);
        @(negedge clk);
        e0 = active && q0.size() != 0 && !dest_full(q0[0]);
        e1 = active && q1.size() != 0 && !dest_full(q1[0]);
        p0 = reset && m_run && e0 && !(e1 && m_burst >= MAXB);
        p1 = reset && m_run && e1 && !p0;
        check({tag, ".pop_vc0"}, {7'd0, pop_vc0}, {7'd0, p0});
        check({tag, ".pop_vc1"}, {7'd0, pop_vc1}, {7'd0, p1});
        check({tag, ".push_d0"}, {7'd0, push_d0}, {7'd0, m_push0});
        check({tag, ".push_d1"}, {7'd0, push_d1}, {7'd0, m_push1});
        check({tag, ".data_out"}, {2'd0, data_out}, {2'd0, m_data});
        check({tag, ".idle"}, {7'd0, idle}, {7'd0, m_idle});
        @(posedge clk);
        if (!reset) begin
            m_run = 0; m_burst = 0; m_push0 = 0; m_push1 = 0; m_data = '0; m_idle = 1;
        end else begin
            m_run  = active;
            m_idle = !(p0 || p1);
            if (p0 || p1) begin
                w       = p0 ? q0.pop_front() : q1.pop_front();
                m_push0 = !w[4];
                m_push1 = w[4];
                m_data  = w;
                m_burst = p1 ? 0 : ((m_burst + 1 > MAXB) ? MAXB : m_burst + 1);
            end else begin
                m_push0 = 0;
                m_push1 = 0;
            end
        end
        #1;
    endtask

    int seq_pops;

    initial begin
        reset = 1'b0; active = 1'b1;
        d0_almost_full = 1'b0; d1_almost_full = 1'b0;
        q0 = '{6'h01, 6'h02}; q1 = '{6'h03};
        vc0_empty = 1'b0; vc1_empty = 1'b0; vc0_data = 6'h01; vc1_data = 6'h03;
        @(posedge clk); #1;

        // Reset with non-empty VCs and active high: everything quiet.
        run_cycle("rst");
        run_cycle("rst");

        // VC0 only, three words with alternating destinations.
        q0 = '{6'h01, 6'h12, 6'h03}; q1.delete();
        reset = 1'b1;
        for (int i = 0; i < 7; i++) run_cycle("vc0_only");

        // Both VCs loaded towards D0: burst limit interleaves VC1.
        for (int i = 0; i < 12; i++) q0.push_back(6'(i & 15));
        for (int i = 0; i < 4; i++)  q1.push_back(6'(8'h20 | i));
        seq_pops = 0;
        for (int i = 0; i < 12; i++) begin
            run_cycle("starve");
            if (i == 4) check("starve.vc1_fifth", {7'd0, push_d0}, 8'd1);
        end
        q0.delete(); q1.delete();
        for (int i = 0; i < 3; i++) run_cycle("drain");

        // VC0 head blocked by D1 almost-full, VC1 to D0 served instead.
        q0 = '{6'h10, 6'h11}; q1 = '{6'h05, 6'h06, 6'h07, 6'h08};
        d1_almost_full = 1'b1;
        for (int i = 0; i < 3; i++) run_cycle("af_block");
        d1_almost_full = 1'b0;
        for (int i = 0; i < 6; i++) run_cycle("af_release");
        q1.delete();

        // Streaming VC0 with a one-cycle drop of active.
        for (int i = 0; i < 10; i++) q0.push_back(6'(i));
        for (int i = 0; i < 3; i++) run_cycle("stream");
        active = 1'b0;
        run_cycle("active_drop");
        active = 1'b1;
        for (int i = 0; i < 4; i++) run_cycle("stream_resume");

        // Reset in the cycle after a pop: pending push discarded.
        reset = 1'b0;
        run_cycle("mid_rst");
        run_cycle("mid_rst_after");
        check("mid_rst.push_d0", {7'd0, push_d0}, 8'd0);
        reset = 1'b1;
        q0.delete();
        for (int i = 0; i < 3; i++) run_cycle("post_rst");

        // Random traffic against the model.
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 2) != 0 && q0.size() < 8) q0.push_back(6'($urandom));
            if ($urandom_range(0, 2) != 0 && q1.size() < 8) q1.push_back(6'($urandom));
            active         = ($urandom_range(0, 7) != 0);
            d0_almost_full = ($urandom_range(0, 3) == 0);
            d1_almost_full = ($urandom_range(0, 3) == 0);
            reset          = ($urandom_range(0, 63) != 0);
            run_cycle("rand");
        end

        // Both destinations almost-full: pipeline drains to idle.
        reset = 1'b1; active = 1'b1;
        d0_almost_full = 1'b1; d1_almost_full = 1'b1;
        for (int i = 0; i < 3; i++) run_cycle("all_full");
        check("all_full.idle", {7'd0, idle}, 8'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
